descriptor_sequencer: RTL and testbench

- Controller that sequences one shared 8-bin orientation histogram accumulator (HistogramSeq-style: clk, en, clr, bin, magnitude, 8-bin output) across the 4x4 subregions of a SIFT keypoint window.
- Accepts a stream of (orientation bin, magnitude) samples from the region classifier, SUB_N samples per subregion.
- Clears the histogram before each subregion, feeds it the samples, captures its result, and emits the NSUB*8-element descriptor serially.

---
 rtl/descriptor_sequencer.sv | 108 ++++++++++
 tb/tb_descriptor_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/descriptor_sequencer.sv
// descriptor_sequencer: time-shares one 8-bin histogram across the subregions of a keypoint window
// and streams the captured bins out as a serial descriptor.
module descriptor_sequencer #(
  parameter int dataW    = 8,
  parameter int SUB_N    = 16,
  parameter int NSUB     = 16,
  parameter int HIST_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [2:0]         pix_bin,
  input  logic [dataW-1:0]   pix_mag,
  output logic               hist_en,
  output logic               hist_clr,
  output logic [2:0]         hist_bin,
  output logic [dataW-1:0]   hist_mag,
  input  logic [8*dataW-1:0] hist_in,
  output logic               desc_valid,
  input  logic               desc_ready,
  output logic [dataW-1:0]   desc_data,
  output logic [6:0]         desc_idx,
  output logic               desc_last,
  output logic               busy,
  output logic               done
);
  localparam int CW = $clog2(SUB_N + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, EMIT, DONE} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         sub_q, sub_d;
  logic [1:0]         wt_q, wt_d;
  logic [2:0]         bin_q, bin_d;
  logic [8*dataW-1:0] shadow_q, shadow_d;
  assign hist_bin = pix_bin;
  assign hist_mag = pix_mag;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sub_q    <= '0;
      wt_q     <= '0;
      bin_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sub_q    <= sub_d;
      wt_q     <= wt_d;
      bin_q    <= bin_d;
      shadow_q <= shadow_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sub_d      = sub_q;
    wt_d       = wt_q;
    bin_d      = bin_q;
    shadow_d   = shadow_q;
    pix_ready  = state_q == ACCUM;
    hist_en    = pix_ready && pix_valid;
    hist_clr   = state_q == CLEAR;
    desc_valid = state_q == EMIT;
    busy       = state_q != IDLE;
    done       = state_q == DONE;
    desc_data  = shadow_q[int'(bin_q)*dataW +: dataW];
    desc_idx   = {sub_q, bin_q};
    desc_last  = desc_valid && sub_q == 4'(NSUB - 1) && bin_q == 3'd7;
    case (state_q)
      IDLE: begin
        state_d = start ? CLEAR : IDLE;
        sub_d   = start ? '0 : sub_q;
      end
      CLEAR: begin
        state_d = ACCUM;
        cnt_d   = '0;
      end
      ACCUM: if (hist_en) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SUB_N - 1)) begin
          state_d = DRAIN;
          wt_d    = '0;
        end
      end
      // hist_in only reflects the final sample HIST_LAT cycles after it was accepted
      DRAIN: begin
        wt_d = wt_q + 1'b1;
        if (wt_q == 2'(HIST_LAT - 1)) begin
          shadow_d = hist_in;
          state_d  = EMIT;
          bin_d    = '0;
        end
      end
      EMIT: if (desc_ready) begin
        bin_d = bin_q + 1'b1;
        if (bin_q == 3'd7) begin
          state_d = sub_q == 4'(NSUB - 1) ? DONE : CLEAR;
          sub_d   = sub_q == 4'(NSUB - 1) ? sub_q : sub_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_descriptor_sequencer.sv
// tb_descriptor_sequencer: two sequencer instances (histogram latency 1 and 3) with behavioural
// histograms; accepted samples build expected descriptors in a queue checked against the output stream.
module tb_descriptor_sequencer;
  localparam int W = 8;
  logic clk = 0, rst_n = 1, start = 0, sel = 0, pix_valid = 0, desc_ready = 1;
  logic [2:0] pix_bin = 0;
  logic [W-1:0] pix_mag = 0;
  always #5 clk = ~clk;

  logic a_pr, a_en, a_clr, a_dv, a_dl, a_busy, a_done, b_pr, b_en, b_clr, b_dv, b_dl, b_busy, b_done;
  logic [2:0] a_hb, b_hb;
  logic [W-1:0] a_hm, b_hm, a_dd, b_dd;
  logic [6:0] a_di, b_di;
  logic [8*W-1:0] a_hin, b_hin, hb_flat, hb_p1;
  logic start_a, start_b;
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  descriptor_sequencer #(.dataW(W), .SUB_N(16), .NSUB(16), .HIST_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .pix_valid(pix_valid), .pix_ready(a_pr),
    .pix_bin(pix_bin), .pix_mag(pix_mag), .hist_en(a_en), .hist_clr(a_clr), .hist_bin(a_hb),
    .hist_mag(a_hm), .hist_in(a_hin), .desc_valid(a_dv), .desc_ready(desc_ready), .desc_data(a_dd),
    .desc_idx(a_di), .desc_last(a_dl), .busy(a_busy), .done(a_done));
  descriptor_sequencer #(.dataW(W), .SUB_N(16), .NSUB(16), .HIST_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .pix_valid(pix_valid), .pix_ready(b_pr),
    .pix_bin(pix_bin), .pix_mag(pix_mag), .hist_en(b_en), .hist_clr(b_clr), .hist_bin(b_hb),
    .hist_mag(b_hm), .hist_in(b_hin), .desc_valid(b_dv), .desc_ready(desc_ready), .desc_data(b_dd),
    .desc_idx(b_di), .desc_last(b_dl), .busy(b_busy), .done(b_done));

  function automatic logic [W-1:0] sat(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[W] ? '1 : s[W-1:0];
  endfunction

  // behavioural histograms; instance b sees its result two extra cycles late
  logic [W-1:0] ha [8], hb [8];
  always_ff @(posedge clk)
    for (int i = 0; i < 8; i++) begin
      if (a_clr) ha[i] <= '0;
      else if (a_en && a_hb == 3'(i)) ha[i] <= sat(ha[i], a_hm);
      if (b_clr) hb[i] <= '0;
      else if (b_en && b_hb == 3'(i)) hb[i] <= sat(hb[i], b_hm);
    end
  always_comb
    for (int i = 0; i < 8; i++) begin
      a_hin[i*W +: W]   = ha[i];
      hb_flat[i*W +: W] = hb[i];
    end
  always_ff @(posedge clk) begin
    hb_p1 <= hb_flat;
    b_hin <= hb_p1;
  end

  logic pix_ready, hist_en, hist_clr, desc_valid, desc_last, busy, done;
  logic [W-1:0] desc_data;
  logic [6:0] desc_idx;
  assign pix_ready  = sel ? b_pr : a_pr;
  assign hist_en    = sel ? b_en : a_en;
  assign hist_clr   = sel ? b_clr : a_clr;
  assign desc_valid = sel ? b_dv : a_dv;
  assign desc_data  = sel ? b_dd : a_dd;
  assign desc_idx   = sel ? b_di : a_di;
  assign desc_last  = sel ? b_dl : a_dl;
  assign busy       = sel ? b_busy : a_busy;
  assign done       = sel ? b_done : a_done;

  // what happened at the last rising edge, read back at the following falling edge
  logic hs_pix, hs_desc, cap_en, cap_clr, cap_last;
  logic [2:0] cap_bin;
  logic [W-1:0] cap_mag, cap_data;
  logic [6:0] cap_idx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {hs_pix, hs_desc, cap_en, cap_clr, cap_last} <= '0;
      cap_bin  <= '0;
      cap_mag  <= '0;
      cap_data <= '0;
      cap_idx  <= '0;
    end else begin
      hs_pix   <= pix_valid & pix_ready;
      hs_desc  <= desc_valid & desc_ready;
      cap_en   <= hist_en;
      cap_clr  <= hist_clr;
      cap_bin  <= pix_bin;
      cap_mag  <= pix_mag;
      cap_data <= desc_data;
      cap_idx  <= desc_idx;
      cap_last <= desc_last;
    end

  int errors = 0, checks = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  typedef struct packed {logic [6:0] idx; logic [W-1:0] data; logic last;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [W-1:0] eh [8] = '{default: '0};
  int acc = 0, sub_e = 0, en_cnt = 0, clr_cnt = 0, done_cnt = 0, bp_left = 0;
  bit bp_arm = 0, bubbles = 0, pat = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      acc = 0;
      sub_e = 0;
      q.delete();
      for (int b = 0; b < 8; b++) eh[b] = '0;
      bp_left = 0;
      desc_ready = 1;
      pix_valid = 0;
    end else begin
      if (cap_en) en_cnt++;
      if (cap_clr) clr_cnt++;
      if (done) done_cnt++;
      if (hs_pix) begin
        eh[cap_bin] = sat(eh[cap_bin], cap_mag);
        acc++;
        if (acc % 16 == 0) begin
          chk("ready_drop", pix_ready, 0);
          for (int b = 0; b < 8; b++) begin
            q.push_back('{idx: 7'(sub_e * 8 + b), data: eh[b], last: sub_e == 15 && b == 7});
            eh[b] = '0;
          end
          sub_e++;
        end
      end
      if (hs_desc) begin
        if (q.size() == 0) chk("desc_extra", cap_idx, 7'h7f);
        else begin
          e = q.pop_front();
          chk("desc_idx", cap_idx, e.idx);
          chk("desc_data", cap_data, e.data);
          chk("desc_last", cap_last, e.last);
          if (e.last) chk("done_after_last", done, 1);
        end
      end
      if (bp_left > 0) begin
        chk("bp_idx", desc_idx, 19);
        chk("bp_data", desc_data, q[0].data);
        chk("bp_pix_ready", pix_ready, 0);
        bp_left--;
        if (bp_left == 0) desc_ready = 1;
      end else if (bp_arm && desc_valid && desc_idx == 7'd19) begin
        bp_arm = 0;
        bp_left = 5;
        desc_ready = 0;
      end
      pix_valid = bubbles ? ~pix_valid : 1'b1;
      pix_bin = pat ? 3'($urandom_range(0, 7)) : 3'(sub_e % 8);
      pix_mag = pat ? W'($urandom_range(1, 15)) : W'(1);
    end
  end

  task automatic run_desc(input int exp_cyc, input bit spur);
    int cyc;
    @(negedge clk);
    acc = 0; sub_e = 0; en_cnt = 0; clr_cnt = 0; done_cnt = 0; cyc = 0;
    start = 1;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = spur && (cyc == 10 || cyc == 22);
      if (cyc == 1) chk("clear_state", {busy, hist_clr, pix_ready}, 3'b110);
      if (done) break;
    end
    start = 0;
    chk("done_seen", done, 1);
    if (exp_cyc > 0) chk("cycles", cyc, exp_cyc);
    repeat (3) @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("done_cnt", done_cnt, 1);
    chk("clr_cnt", clr_cnt, 16);
    chk("en_cnt", en_cnt, 256);
    chk("q_empty", q.size(), 0);
  endtask

  initial begin
    #2 rst_n = 0;
    #1;
    chk("rst_outputs", {pix_ready, hist_en, hist_clr, desc_valid, desc_last, busy, done}, 0);
    chk("rst_desc", {desc_data, desc_idx}, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1;
    run_desc(417, 1);
    bubbles = 1;
    run_desc(0, 0);
    bubbles = 0;
    pat = 1;
    bp_arm = 1;
    run_desc(422, 0);
    chk("bp_hit", bp_arm, 0);
    pat = 0;
    @(negedge clk);
    acc = 0; sub_e = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 3000 && acc < 53; i++) begin
      @(negedge clk);
      #1;
    end
    chk("reach_sub3_cnt5", acc, 53);
    chk("mid_accum", {busy, pix_ready}, 2'b11);
    rst_n = 0;
    #1;
    chk("async_rst_outputs", {pix_ready, hist_en, hist_clr, desc_valid, desc_last, busy, done}, 0);
    chk("async_rst_desc", {desc_data, desc_idx}, 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1;
    run_desc(417, 0);
    sel = 1;
    run_desc(449, 0);
    pat = 1;
    run_desc(449, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
